scu_dsp_dma_resp: RTL and testbench
===================================

SCU_DSP_DMA_RESP -- requirements
Module: scu_dsp_dma_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, giving the external byte-address width.
REQ-002 SHALL have parameter END_LEN, default 2, giving the number of CE cycles DMA_END is held high.
REQ-003 CLK  in  1  system clock; the block has one clock only.
REQ-004 RST_N  in  1  reset, asynchronous and active-low.
REQ-005 CE  in  1  clock enable; all state SHALL advance only when CE=1, except RST_N.
REQ-006 RES_N  in  1  synchronous soft reset, active-low, qualified by CE.
REQ-007 DSO  in  32  DSP data/instruction strobe bus.
REQ-008 RA0W, WA0W, DMAW  in  1 each  one-cycle strobes: load RA0, load WA0, start DMA.
REQ-009 DMA_REQ, DMA_RUN, DMA_LAST  in  1 each  DSP word request, DMA active, final word.
REQ-010 DMA_DO  in  32  DSP write data (DSP to bus).
REQ-011 DMA_DI  out  32  read data to DSP; DMA_ACK  out  1  word-done pulse; DMA_END  out  1  transfer-end flag.
REQ-012 BUS_A  out  ADDR_W  byte address; BUS_DO  out  32; BUS_DI  in  32; BUS_WE  out  1; BUS_REQ  out  1; BUS_ACK  in  1.

Function
REQ-013 SHALL hold 25-bit word pointers RA0 and WA0; in IDLE, RA0W loads RA0<=DSO[24:0] and WA0W loads WA0<=DSO[24:0].
REQ-014 RA0W or WA0W outside IDLE SHALL be ignored.
REQ-015 On DMAW in IDLE: latch DIR=DSO[12] (1 = DSP to bus), HOLD=DSO[14], ADD=DSO[17:15]; load PTR from WA0 if DIR=1, else RA0; go to WAIT_REQ.
REQ-016 DMAW outside IDLE SHALL be ignored.
REQ-017 Step in words SHALL be 0 when ADD=0, otherwise 1<<(ADD-1); PTR arithmetic is modulo 2^25.
REQ-018 States: IDLE, WAIT_REQ, BUS, ACK, END.
REQ-019 WAIT_REQ: when DMA_REQ=1 and DMA_RUN=1, latch LAST=DMA_LAST and WDATA=DMA_DO, then go to BUS.
REQ-020 BUS: BUS_REQ=1, BUS_A={PTR,2'b00} zero-extended or truncated to ADDR_W, BUS_WE=DIR, BUS_DO=WDATA; all held stable until BUS_ACK.
REQ-021 BUS with BUS_ACK=1: drop BUS_REQ the next cycle; if DIR=0, capture DMA_DI<=BUS_DI; PTR<=PTR+step; go to ACK.
REQ-022 ACK: DMA_ACK=1 for exactly one CE cycle; then go to END if LAST=1, else to WAIT_REQ.
REQ-023 END entry: unless HOLD=1, write PTR back to WA0 (DIR=1) or RA0 (DIR=0).
REQ-024 END: DMA_END=1 for END_LEN CE cycles, then 0, then go to IDLE; the DSP detects completion on the falling edge.
REQ-025 DMA_RUN falling in WAIT_REQ SHALL go to END with the same write-back rule.
REQ-026 DMA_DI SHALL hold its last captured value between reads.
REQ-027 Latency from DMA_REQ sampled to DMA_ACK SHALL be 2 CE cycles plus the BUS_ACK wait.
REQ-028 BUS_ACK outside BUS SHALL be ignored.
REQ-029 CE=0 SHALL freeze all state and outputs; a BUS_ACK arriving while CE=0 is not captured.

Reset
REQ-030 RST_N low (asynchronous) or RES_N low (at CE) SHALL force IDLE.
REQ-031 Reset values: RA0=WA0=PTR=0; DMA_DI=0; DMA_ACK=DMA_END=BUS_REQ=BUS_WE=0; BUS_A=BUS_DO=0.
REQ-032 Reset mid-BUS SHALL drop BUS_REQ immediately with no write-back and no DMA_ACK.

Verification
REQ-033 RA0W with DSO=0x0000_0100, then DMAW with DIR=0, ADD=1, and 3 requests with the third LAST -> BUS_A reads 0x400, 0x404, 0x408; 3 DMA_ACK pulses; DMA_END high 2 cycles; RA0=0x103.
REQ-034 WA0W with DSO=0x0000_0040, then DMAW with DIR=1, HOLD=1, ADD=2, and 2 words 0xDEADBEEF and 0x12345678 -> BUS_WE=1 at 0x100 then 0x108 with matching BUS_DO; WA0 stays 0x40.
REQ-035 BUS_ACK delayed 5 cycles -> BUS_REQ, BUS_A and BUS_DO stay stable for all 5 cycles; DMA_ACK fires one cycle after the BUS_ACK cycle.
REQ-036 RA0=0x1FF_FFFF with ADD=1 and 2 words -> second address is 0x0; RA0=0x1 after write-back.
REQ-037 RST_N pulsed low while in BUS -> BUS_REQ=0 in the same cycle; state IDLE; RA0=WA0=0; no DMA_END.
REQ-038 RA0W during an active transfer and DMAW in END -> both ignored; the pointer and the next transfer are unaffected.

Source files
------------

// File: rtl/scu_dsp_dma_resp_if.sv
// rtl/scu_dsp_dma_resp_if.sv - external bus handshake bundle for the DSP DMA responder
//   BUS_A   byte address            (master -> slave)
//   BUS_DO  write data              (master -> slave)
//   BUS_WE  write enable            (master -> slave)
//   BUS_REQ request, held until ack (master -> slave)
//   BUS_DI  read data               (slave -> master)
//   BUS_ACK transfer done           (slave -> master)
interface scu_dsp_dma_resp_if #(
    parameter int ADDR_W = 27
);
    logic [ADDR_W-1:0] BUS_A;
    logic [31:0]       BUS_DO;
    logic [31:0]       BUS_DI;
    logic              BUS_WE;
    logic              BUS_REQ;
    logic              BUS_ACK;

    modport master (
        output BUS_A, BUS_DO, BUS_WE, BUS_REQ,
        input  BUS_DI, BUS_ACK
    );

    modport slave (
        input  BUS_A, BUS_DO, BUS_WE, BUS_REQ,
        output BUS_DI, BUS_ACK
    );
endinterface

// File: rtl/scu_dsp_dma_resp.sv
// rtl/scu_dsp_dma_resp.sv - DSP DMA responder: moves words between the DSP and an external bus
//   CLK, RST_N        clock, asynchronous active-low reset
//   CE, RES_N         clock enable, CE-qualified synchronous active-low soft reset
//   DSO               DSP strobe bus (pointer values and DMA command word)
//   RA0W, WA0W, DMAW  load read pointer, load write pointer, start DMA
//   DMA_REQ/RUN/LAST  DSP word request, transfer active, final word
//   DMA_DO, DMA_DI    DSP write data in, read data out
//   DMA_ACK, DMA_END  per-word done pulse, transfer-end flag
//   bus               external bus master (address, data, request/ack)
module scu_dsp_dma_resp #(
    parameter int ADDR_W  = 27,
    parameter int END_LEN = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        RES_N,
    input  logic [31:0] DSO,
    input  logic        RA0W,
    input  logic        WA0W,
    input  logic        DMAW,
    input  logic        DMA_REQ,
    input  logic        DMA_RUN,
    input  logic        DMA_LAST,
    input  logic [31:0] DMA_DO,
    output logic [31:0] DMA_DI,
    output logic        DMA_ACK,
    output logic        DMA_END,
    scu_dsp_dma_resp_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_REQ, S_BUS, S_ACK, S_END} state_t;

    localparam int CNT_W = (END_LEN > 1) ? $clog2(END_LEN) : 1;

    state_t            state, state_nx;
    logic [24:0]       ra0, wa0, ptr, step;
    logic              dir, hold, last;
    logic [2:0]        add;
    logic [31:0]       wdata, dma_di;
    logic [CNT_W-1:0]  end_cnt;
    logic              enter_end;
    logic [26:0]       byte_addr;
    logic              unused_dso;

    assign unused_dso = ^DSO[31:25];

    assign step      = (add == 3'd0) ? 25'd0 : (25'd1 << (add - 3'd1));
    assign enter_end = (state_nx == S_END) && (state != S_END);
    assign byte_addr = {ptr, 2'b00};

    // Bus outputs are decoded from state so an asynchronous reset drops
    // BUS_REQ in the same cycle, and outside BUS everything reads as zero.
    assign bus.BUS_REQ = (state == S_BUS);
    assign bus.BUS_WE  = (state == S_BUS) & dir;
    assign bus.BUS_A   = (state == S_BUS) ? ADDR_W'(byte_addr) : '0;
    assign bus.BUS_DO  = (state == S_BUS) ? wdata : 32'd0;
    assign DMA_ACK     = (state == S_ACK);
    assign DMA_END     = (state == S_END);
    assign DMA_DI      = dma_di;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (DMAW) state_nx = S_WAIT_REQ;
            // A dropped DMA_RUN wins over a coincident request.
            S_WAIT_REQ: if (!DMA_RUN) state_nx = S_END;
                        else if (DMA_REQ) state_nx = S_BUS;
            S_BUS:      if (bus.BUS_ACK) state_nx = S_ACK;
            S_ACK:      state_nx = last ? S_END : S_WAIT_REQ;
            S_END:      if (end_cnt == CNT_W'(END_LEN - 1)) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else if (CE) begin
            if (!RES_N) state <= S_IDLE;
            else        state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ra0 <= '0; wa0 <= '0; ptr <= '0;
            dir <= 1'b0; hold <= 1'b0; last <= 1'b0; add <= '0;
            wdata <= '0; dma_di <= '0; end_cnt <= '0;
        end else if (CE) begin
            if (!RES_N) begin
                ra0 <= '0; wa0 <= '0; ptr <= '0;
                dir <= 1'b0; hold <= 1'b0; last <= 1'b0; add <= '0;
                wdata <= '0; dma_di <= '0; end_cnt <= '0;
            end else begin
                if (state == S_IDLE) begin
                    if (RA0W) ra0 <= DSO[24:0];
                    if (WA0W) wa0 <= DSO[24:0];
                    if (DMAW) begin
                        dir  <= DSO[12];
                        hold <= DSO[14];
                        add  <= DSO[17:15];
                        ptr  <= DSO[12] ? wa0 : ra0;
                    end
                end
                if (state == S_WAIT_REQ && DMA_RUN && DMA_REQ) begin
                    last  <= DMA_LAST;
                    wdata <= DMA_DO;
                end
                if (state == S_BUS && bus.BUS_ACK) begin
                    if (!dir) dma_di <= bus.BUS_DI;
                    ptr <= ptr + step;
                end
                if (enter_end && !hold) begin
                    if (dir) wa0 <= ptr;
                    else     ra0 <= ptr;
                end
                end_cnt <= (state == S_END) ? end_cnt + 1'b1 : '0;
            end
        end
    end
endmodule

// File: tb/tb_scu_dsp_dma_resp.sv
// tb/tb_scu_dsp_dma_resp.sv - self-checking bench for scu_dsp_dma_resp
module tb_scu_dsp_dma_resp;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0, CE = 1'b1, RES_N = 1'b1;
    logic [31:0] DSO = '0;
    logic        RA0W = 0, WA0W = 0, DMAW = 0;
    logic        DMA_REQ = 0, DMA_RUN = 0, DMA_LAST = 0;
    logic [31:0] DMA_DO = '0, DMA_DI;
    logic        DMA_ACK, DMA_END;

    scu_dsp_dma_resp_if #(.ADDR_W(27)) bus_if ();

    scu_dsp_dma_resp #(.ADDR_W(27), .END_LEN(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .RES_N(RES_N), .DSO(DSO),
        .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW),
        .DMA_REQ(DMA_REQ), .DMA_RUN(DMA_RUN), .DMA_LAST(DMA_LAST),
        .DMA_DO(DMA_DO), .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END),
        .bus(bus_if)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [26:0] a;
        logic        we;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        bit          dir;
        bit          hold;
        logic [2:0]  add;
        logic [24:0] ptr;
        int          n;
        int          delay;
        bit          freeze;
        logic [31:0] d0, d1;
        logic [24:0] exp_ptr;
    } vec_t;

    beat_t       beat_q[$];
    vec_t        vt[5];
    int          n_chk = 0, n_fail = 0;
    logic [24:0] m_ra0 = '0, m_wa0 = '0, m_ptr = '0, m_step = '0;
    logic        m_dir = 1'b0;
    logic [31:0] m_di = '0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_ptr(input bit w, input logic [24:0] v);
        DSO = {7'd0, v};
        if (w) WA0W = 1'b1; else RA0W = 1'b1;
        tick();
        WA0W = 1'b0; RA0W = 1'b0;
        if (w) m_wa0 = v; else m_ra0 = v;
    endtask

    task automatic start_dma(input bit dir, input bit hold, input logic [2:0] add);
        DSO = {14'd0, add, hold, 1'b0, dir, 12'd0};
        DMAW = 1'b1; DMA_RUN = 1'b1;
        tick();
        DMAW = 1'b0;
        m_dir  = dir;
        m_step = (add == 3'd0) ? 25'd0 : (25'd1 << (add - 3'd1));
        m_ptr  = dir ? m_wa0 : m_ra0;
        chk("start_no_req", bus_if.BUS_REQ, 0);
    endtask

    // One word from WAIT_REQ through ACK; expectations queued at request time.
    task automatic do_word(input bit last, input logic [31:0] wd, input logic [31:0] rd,
                           input int delay, input bit poke, input bit freeze);
        beat_t b, e;
        b.a = {m_ptr, 2'b00}; b.we = m_dir; b.d = wd;
        beat_q.push_back(b);
        DMA_REQ = 1'b1; DMA_LAST = last; DMA_DO = wd;
        if (poke) begin RA0W = 1'b1; DSO = 32'h0000_0777; end
        tick();
        DMA_REQ = 1'b0; DMA_LAST = 1'b0; RA0W = 1'b0; DMA_DO = $urandom;
        if (freeze) begin
            CE = 1'b0; bus_if.BUS_ACK = 1'b1;
            tick();
            CE = 1'b1; bus_if.BUS_ACK = 1'b0;
            chk("freeze_req", bus_if.BUS_REQ, 1);
            chk("freeze_ack", DMA_ACK, 0);
        end
        if (beat_q.size() == 0) begin
            chk("beat_q_empty", 1, 0);
            e = b;
        end else begin
            e = beat_q.pop_front();
        end
        for (int k = 0; k <= delay; k++) begin
            chk("bus_req", bus_if.BUS_REQ, 1);
            chk("bus_a", bus_if.BUS_A, e.a);
            chk("bus_we", bus_if.BUS_WE, e.we);
            chk("bus_do", bus_if.BUS_DO, e.d);
            chk("early_ack", DMA_ACK, 0);
            if (k == delay) begin bus_if.BUS_ACK = 1'b1; bus_if.BUS_DI = rd; end
            tick();
            bus_if.BUS_ACK = 1'b0; bus_if.BUS_DI = $urandom;
        end
        if (!m_dir) m_di = rd;
        m_ptr = m_ptr + m_step;
        chk("dma_ack", DMA_ACK, 1);
        chk("req_dropped", bus_if.BUS_REQ, 0);
        chk("dma_di", DMA_DI, m_di);
        tick();
        chk("ack_one_cycle", DMA_ACK, 0);
    endtask

    task automatic check_end(input bit poke_dmaw);
        chk("end_c0", DMA_END, 1);
        if (poke_dmaw) begin DMAW = 1'b1; DSO = 32'h0000_1000; end
        tick();
        DMAW = 1'b0;
        chk("end_c1", DMA_END, 1);
        tick();
        chk("end_fall", DMA_END, 0);
        DMA_RUN = 1'b0;
    endtask

    // Reads back a written-back pointer through the address of a one-word transfer.
    task automatic probe(input bit dir, input logic [24:0] exp);
        if (dir) m_wa0 = exp; else m_ra0 = exp;
        start_dma(dir, 1'b1, 3'd0);
        do_word(1'b1, $urandom, $urandom, 0, 1'b0, 1'b0);
        check_end(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.BUS_ACK = 1'b0; bus_if.BUS_DI = '0;
        vt[0] = '{dir:0, hold:0, add:3'd1, ptr:25'h100,     n:3, delay:0, freeze:0,
                  d0:32'h0, d1:32'h0, exp_ptr:25'h103};
        vt[1] = '{dir:1, hold:1, add:3'd2, ptr:25'h40,      n:2, delay:0, freeze:0,
                  d0:32'hDEADBEEF, d1:32'h12345678, exp_ptr:25'h40};
        vt[2] = '{dir:0, hold:0, add:3'd3, ptr:25'h55,      n:1, delay:5, freeze:1,
                  d0:32'h0, d1:32'h0, exp_ptr:25'h59};
        vt[3] = '{dir:0, hold:0, add:3'd1, ptr:25'h1FFFFFF, n:2, delay:0, freeze:0,
                  d0:32'h0, d1:32'h0, exp_ptr:25'h1};
        vt[4] = '{dir:1, hold:0, add:3'd7, ptr:25'h10,      n:2, delay:2, freeze:0,
                  d0:32'hA5A5_0001, d1:32'h5A5A_0002, exp_ptr:25'h90};

        tick(); tick();
        chk("rst_bus_req", bus_if.BUS_REQ, 0);
        chk("rst_bus_we", bus_if.BUS_WE, 0);
        chk("rst_bus_a", bus_if.BUS_A, 0);
        chk("rst_bus_do", bus_if.BUS_DO, 0);
        chk("rst_dma_ack", DMA_ACK, 0);
        chk("rst_dma_end", DMA_END, 0);
        chk("rst_dma_di", DMA_DI, 0);
        RST_N = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            load_ptr(vt[v].dir, vt[v].ptr);
            start_dma(vt[v].dir, vt[v].hold, vt[v].add);
            for (int i = 0; i < vt[v].n; i++) begin
                logic [31:0] wd;
                wd = (i == 0) ? vt[v].d0 : (i == 1) ? vt[v].d1 : $urandom;
                do_word(i == vt[v].n - 1, wd, $urandom, vt[v].delay, 1'b0,
                        vt[v].freeze && i == 0);
            end
            check_end(1'b0);
            probe(vt[v].dir, vt[v].exp_ptr);
        end

        // RA0W mid-transfer, stray BUS_ACK in WAIT_REQ, DMAW during END: all ignored.
        load_ptr(1'b1, 25'h3AB);
        load_ptr(1'b0, 25'h200);
        start_dma(1'b0, 1'b0, 3'd1);
        bus_if.BUS_ACK = 1'b1;
        tick();
        bus_if.BUS_ACK = 1'b0;
        chk("stray_ack", DMA_ACK, 0);
        do_word(1'b0, $urandom, $urandom, 0, 1'b1, 1'b0);
        do_word(1'b1, $urandom, $urandom, 1, 1'b0, 1'b0);
        check_end(1'b1);
        tick();
        chk("idle_no_req", bus_if.BUS_REQ, 0);
        probe(1'b0, 25'h202);
        probe(1'b1, 25'h3AB);

        // DMA_RUN falling in WAIT_REQ ends the transfer with write-back.
        load_ptr(1'b0, 25'h10);
        start_dma(1'b0, 1'b0, 3'd2);
        do_word(1'b0, $urandom, $urandom, 0, 1'b0, 1'b0);
        DMA_RUN = 1'b0;
        tick();
        check_end(1'b0);
        probe(1'b0, 25'h12);

        // Asynchronous reset while the bus request is outstanding.
        load_ptr(1'b0, 25'h20);
        load_ptr(1'b1, 25'h30);
        start_dma(1'b0, 1'b0, 3'd1);
        DMA_REQ = 1'b1;
        tick();
        DMA_REQ = 1'b0;
        chk("pre_rst_req", bus_if.BUS_REQ, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_req_drop", bus_if.BUS_REQ, 0);
        chk("async_no_ack", DMA_ACK, 0);
        chk("async_bus_a", bus_if.BUS_A, 0);
        tick();
        RST_N = 1'b1; DMA_RUN = 1'b0;
        m_di = 32'd0;
        tick();
        chk("post_rst_end", DMA_END, 0);
        chk("post_rst_ack", DMA_ACK, 0);
        chk("post_rst_di", DMA_DI, 0);
        tick();
        chk("post_rst_end2", DMA_END, 0);
        probe(1'b0, 25'h0);
        probe(1'b1, 25'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
